// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and sizing constants for the data-memory responder.
package dmem_pkg;

  // Load encodings (req_rd_ctrl); 3'b111 is reserved and decoded as a doubleword load.
  localparam logic [2:0] Lb  = 3'b000;
  localparam logic [2:0] Lbu = 3'b001;
  localparam logic [2:0] Lh  = 3'b010;
  localparam logic [2:0] Lhu = 3'b011;
  localparam logic [2:0] Lw  = 3'b100;
  localparam logic [2:0] Lwu = 3'b101;
  localparam logic [2:0] Ld  = 3'b110;

  // Store encodings (req_wr_ctrl).
  localparam logic [1:0] Sb = 2'b00;
  localparam logic [1:0] Sh = 2'b01;
  localparam logic [1:0] Sw = 2'b10;
  localparam logic [1:0] Sd = 2'b11;

  localparam int unsigned DefaultDepthWords = 1024;
  localparam int unsigned DefaultIdxW       = $clog2(DefaultDepthWords);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  // Low address bits that must be zero for an access of log2-size sz.
  function automatic logic [2:0] size_mask(input logic [1:0] sz);
    unique case (sz)
      2'd0:    size_mask = 3'b000;
      2'd1:    size_mask = 3'b001;
      2'd2:    size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: load extract/extend and store merge with byte enables.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [63:0] word_i,
  input  logic [2:0]  off_i,
  input  logic [2:0]  rd_ctrl_i,
  input  logic [1:0]  wr_ctrl_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] ld_data_o,
  output logic [63:0] st_data_o,
  output logic [7:0]  be_o
);

  logic [5:0]  bit_off;
  logic [63:0] sh_word;
  logic [63:0] sh_wdata;
  logic [7:0]  be_base;

  assign bit_off = {off_i, 3'b000};

  always_comb begin
    sh_word   = word_i >> bit_off;
    ld_data_o = sh_word;
    case (rd_ctrl_i)
      Lb:      ld_data_o = {{56{sh_word[7]}}, sh_word[7:0]};
      Lbu:     ld_data_o = {56'd0, sh_word[7:0]};
      Lh:      ld_data_o = {{48{sh_word[15]}}, sh_word[15:0]};
      Lhu:     ld_data_o = {48'd0, sh_word[15:0]};
      Lw:      ld_data_o = {{32{sh_word[31]}}, sh_word[31:0]};
      Lwu:     ld_data_o = {32'd0, sh_word[31:0]};
      default: ld_data_o = sh_word;
    endcase
  end

  always_comb begin
    sh_wdata = wdata_i << bit_off;
    be_base  = 8'hff;
    unique case (wr_ctrl_i)
      Sb:      be_base = 8'h01;
      Sh:      be_base = 8'h03;
      Sw:      be_base = 8'h0f;
      default: be_base = 8'hff;
    endcase
    be_o      = be_base << off_i;
    st_data_o = word_i;
    for (int i = 0; i < 8; i++) begin
      if (be_o[i]) st_data_o[8*i +: 8] = sh_wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle RV64 data-memory responder with valid/ready request and response channels.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned accesses with rsp_err instead of aligning down.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DefaultDepthWords,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_rd_ctrl,
  input  logic [1:0]  req_wr_ctrl,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);
  localparam bit          Direct  = (LATENCY == 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       rd_ctrl_q, rd_ctrl_d;
  logic [1:0]       wr_ctrl_q, wr_ctrl_d;
  logic [IdxW+2:0]  addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [63:0]      mem [DEPTH_WORDS];

  logic             accept, enter_resp, in_idle;
  logic             acc_we, misalign;
  logic [2:0]       acc_rd_ctrl, acc_off, mask;
  logic [1:0]       acc_wr_ctrl, acc_sz;
  logic [IdxW+2:0]  acc_addr;
  logic [63:0]      acc_wdata, old_word, ld_data, st_data;
  logic [IdxW-1:0]  idx;
  logic [7:0]       be;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^req_addr[63:IdxW+3];

  assign in_idle    = (state_q == StIdle);
  assign accept     = req_valid && in_idle;
  assign enter_resp = (Direct && accept) || ((state_q == StWait) && (cnt_q == 4'd0));

  // With LATENCY==1 the access happens on the accepting edge, so use the live request.
  assign acc_we      = in_idle ? req_we : we_q;
  assign acc_rd_ctrl = in_idle ? req_rd_ctrl : rd_ctrl_q;
  assign acc_wr_ctrl = in_idle ? req_wr_ctrl : wr_ctrl_q;
  assign acc_addr    = in_idle ? req_addr[IdxW+2:0] : addr_q;
  assign acc_wdata   = in_idle ? req_wdata : wdata_q;

  assign acc_sz = acc_we ? acc_wr_ctrl : acc_rd_ctrl[2:1];
  assign mask   = size_mask(acc_sz);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = |(acc_addr[2:0] & mask);
  assign acc_off  = acc_addr[2:0];
`else
  assign misalign = 1'b0;
  assign acc_off  = acc_addr[2:0] & ~mask;
`endif

  assign idx      = acc_addr[IdxW+2:3];
  assign old_word = mem[idx];

  dmem_lane_fmt u_lane_fmt (
    .word_i    (old_word),
    .off_i     (acc_off),
    .rd_ctrl_i (acc_rd_ctrl),
    .wr_ctrl_i (acc_wr_ctrl),
    .wdata_i   (acc_wdata),
    .ld_data_o (ld_data),
    .st_data_o (st_data),
    .be_o      (be)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      rd_ctrl_q <= 3'd0;
      wr_ctrl_q <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= 64'd0;
      rdata_q   <= 64'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      rd_ctrl_q <= rd_ctrl_d;
      wr_ctrl_q <= wr_ctrl_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Array is not reset; the merged word already carries the unselected lanes.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_we && !misalign && (be != 8'd0)) begin
      mem[idx] <= st_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    rd_ctrl_d = rd_ctrl_q;
    wr_ctrl_d = wr_ctrl_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d      = req_we;
          rd_ctrl_d = req_rd_ctrl;
          wr_ctrl_d = req_wr_ctrl;
          addr_d    = req_addr[IdxW+2:0];
          wdata_d   = req_wdata;
          cnt_d     = CntInit;
          state_d   = Direct ? StResp : StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      rdata_d = (acc_we || misalign) ? 64'd0 : ld_data;
      err_d   = misalign;
    end
  end

  always_comb begin
    req_ready = in_idle;
    rsp_valid = (state_q == StResp);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus backpressure, reset and alignment sequences.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned Lat = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_rd_ctrl;
  logic [1:0]  req_wr_ctrl;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(Lat)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_rd_ctrl(req_rd_ctrl),
    .req_wr_ctrl(req_wr_ctrl),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic we, input logic [2:0] rd, input logic [1:0] wr,
                      input logic [63:0] addr, input logic [63:0] wdata);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready before send", {63'd0, req_ready}, 64'd1);
    req_valid   = 1'b1;
    req_we      = we;
    req_rd_ctrl = rd;
    req_wr_ctrl = wr;
    req_addr    = addr;
    req_wdata   = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!rsp_valid && lat < 20);
    chk({name, " latency"}, 64'(lat), 64'(Lat));
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic do_req(input string name, input logic we, input logic [2:0] rd,
                        input logic [1:0] wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_rdata, input logic exp_err);
    send(we, rd, wr, addr, wdata);
    wait_rsp(name);
    chk({name, " rdata"}, rsp_rdata, exp_rdata);
    chk({name, " err"}, {63'd0, rsp_err}, {63'd0, exp_err});
    finish_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;

    // addr, data, expected load result
    vecs.push_back('{1'b1, 3'd0, Sd,  64'h10,   64'h8877665544332211, 64'h0, 1'b0});
    vecs.push_back('{1'b0, Ld,   2'd0, 64'h10,  64'h0, 64'h8877665544332211, 1'b0});
    vecs.push_back('{1'b0, Lb,   2'd0, 64'h17,  64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0});
    vecs.push_back('{1'b0, Lbu,  2'd0, 64'h17,  64'h0, 64'h0000000000000088, 1'b0});
    vecs.push_back('{1'b0, Lh,   2'd0, 64'h16,  64'h0, 64'hFFFFFFFFFFFF8877, 1'b0});
    vecs.push_back('{1'b0, Lwu,  2'd0, 64'h14,  64'h0, 64'h0000000088776655, 1'b0});
    vecs.push_back('{1'b1, 3'd0, Sb,  64'h11,   64'h123456789ABCDEAB, 64'h0, 1'b0});
    vecs.push_back('{1'b0, Ld,   2'd0, 64'h10,  64'h0, 64'h887766554433AB11, 1'b0});
    vecs.push_back('{1'b0, Ld,   2'd0, 64'h2010, 64'h0, 64'h887766554433AB11, 1'b0});
    vecs.push_back('{1'b1, 3'd0, Sh,  64'h2014, 64'h000000000000CAFE, 64'h0, 1'b0});
    vecs.push_back('{1'b0, Ld,   2'd0, 64'h10,  64'h0, 64'h8877CAFE4433AB11, 1'b0});
    vecs.push_back('{1'b0, Lhu,  2'd0, 64'h14,  64'h0, 64'h000000000000CAFE, 1'b0});
    vecs.push_back('{1'b0, Lw,   2'd0, 64'h10,  64'h0, 64'h000000004433AB11, 1'b0});
    vecs.push_back('{1'b0, Lh,   2'd0, 64'h12,  64'h0, 64'h0000000000004433, 1'b0});
    vecs.push_back('{1'b0, Lb,   2'd0, 64'h10,  64'h0, 64'h0000000000000011, 1'b0});
    vecs.push_back('{1'b0, 3'b111, 2'd0, 64'h10, 64'h0, 64'h8877CAFE4433AB11, 1'b0});
    vecs.push_back('{1'b1, 3'd0, Sw,  64'h14,   64'hFFFFFFFF80000001, 64'h0, 1'b0});
    vecs.push_back('{1'b0, Lw,   2'd0, 64'h14,  64'h0, 64'hFFFFFFFF80000001, 1'b0});

    rst         = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_rd_ctrl = 3'd0;
    req_wr_ctrl = 2'd0;
    req_addr    = 64'd0;
    req_wdata   = 64'd0;
    rsp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rsp_valid in reset", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("req_ready after reset", {63'd0, req_ready}, 64'd1);
    chk("rsp_rdata after reset", rsp_rdata, 64'd0);
    chk("rsp_err after reset", {63'd0, rsp_err}, 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].rd, vecs[i].wr, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Backpressure: hold the response, try to sneak in another request.
    send(1'b0, Ld, 2'd0, 64'h10, 64'h0);
    wait_rsp("hold");
    held = 64'h800000014433AB11;
    chk("hold rdata", rsp_rdata, held);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_wr_ctrl = Sd;
    req_addr  = 64'h10;
    req_wdata = 64'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d rsp_valid", c), {63'd0, rsp_valid}, 64'd1);
      chk($sformatf("hold%0d rdata", c), rsp_rdata, held);
      chk($sformatf("hold%0d req_ready", c), {63'd0, req_ready}, 64'd0);
    end
    req_valid = 1'b0;
    finish_rsp();
    chk("release req_ready", {63'd0, req_ready}, 64'd1);
    chk("release rsp_valid", {63'd0, rsp_valid}, 64'd0);
    do_req("after hold", 1'b0, Lb, 2'd0, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0);
    do_req("ignored store", 1'b0, Ld, 2'd0, 64'h10, 64'h0, held, 1'b0);

    // Reset during WAIT drops a store.
    do_req("seed 0x20", 1'b1, 3'd0, Sd, 64'h20, 64'h0123456789ABCDEF, 64'h0, 1'b0);
    send(1'b1, 3'd0, Sw, 64'h20, 64'h00000000DEADBEEF);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst wait rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst wait req_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1 chk("rst wait rsp_valid later", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk) rst = 1'b0;
    do_req("after rst wait", 1'b0, Lw, 2'd0, 64'h20, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0);

    // Reset during RESP keeps a committed store and drops rsp_valid asynchronously.
    send(1'b1, 3'd0, Sb, 64'h21, 64'h55);
    wait_rsp("rst resp");
    #2 rst = 1'b1;
    #1;
    chk("rst resp rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst resp rdata", rsp_rdata, 64'd0);
    @(negedge clk) rst = 1'b0;
    do_req("after rst resp", 1'b0, Ld, 2'd0, 64'h20, 64'h0, 64'h0123456789AB55EF, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
    do_req("mis lw", 1'b0, Lw, 2'd0, 64'h22, 64'h0, 64'h0, 1'b1);
    do_req("mis sd", 1'b1, 3'd0, Sd, 64'h23, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1);
    do_req("mis check", 1'b0, Ld, 2'd0, 64'h20, 64'h0, 64'h0123456789AB55EF, 1'b0);
`else
    do_req("align lw", 1'b0, Lw, 2'd0, 64'h22, 64'h0, 64'hFFFFFFFF89AB55EF, 1'b0);
    do_req("align lh", 1'b0, Lh, 2'd0, 64'h21, 64'h0, 64'h00000000000055EF, 1'b0);
    do_req("align ld", 1'b0, Ld, 2'd0, 64'h27, 64'h0, 64'h0123456789AB55EF, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
